// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the pushbutton conditioner.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_COUNT = 2'd1,
    ST_RUN   = 2'd2
  } rst_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 250000;

  // Width needed to hold values up to max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button pin / conditioned-event bundle between the board pins and the SoC.
interface button_conditioner_if #(
  parameter int unsigned NUM_BTN = 4
);
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic               cpu_resetn;

  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release, cpu_resetn
  );

  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release, cpu_resetn
  );
endinterface

// File: rtl/button_conditioner_btn_debounce_ch.sv
// One button channel: polarity fix, 2-FF synchronizer, stable-count debounce, edge pulses.
module btn_debounce_ch
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic        ACTIVE_LOW      = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  // Any cycle where the synchronized input agrees with the level restarts the count.
  always_comb begin
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d     = '0;
      level_d   = s2_q;
      press_d   = s2_q;
      release_d = ~s2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= btn_raw_i ^ ACTIVE_LOW;
      s2_q      <= s1_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces the board pushbuttons and stretches the reset button into cpu_resetn.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned        NUM_BTN         = 4,
  parameter logic [NUM_BTN-1:0] ACTIVE_LOW_MASK = 4'b0001,
  parameter int unsigned        DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned        RST_BTN         = 0,
  parameter int unsigned        RST_HOLD        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  button_conditioner_if.slave  bus_if
);

  localparam int unsigned   RW      = cnt_width(RST_HOLD);
  localparam logic [RW-1:0] RC_LAST = RW'(RST_HOLD - 1);

  logic [NUM_BTN-1:0] level_w, press_w, release_w;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW_MASK[g])
    ) u_ch (
      .clk_i     (clk),
      .rst_i     (reset),
      .btn_raw_i (bus_if.btn_raw[g]),
      .level_o   (level_w[g]),
      .press_o   (press_w[g]),
      .release_o (release_w[g])
    );
  end

  rst_state_e    state_q;
  logic [RW-1:0] rc_q;
  logic          resetn_q;
  logic          rst_btn;

  assign rst_btn = level_w[RST_BTN];

  // cpu_resetn is updated together with the state so it only rises on entry to RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_HOLD;
      rc_q     <= '0;
      resetn_q <= 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          rc_q     <= '0;
          resetn_q <= 1'b0;
          if (!rst_btn) state_q <= ST_COUNT;
        end
        ST_COUNT: begin
          if (rst_btn) begin
            state_q  <= ST_HOLD;
            rc_q     <= '0;
            resetn_q <= 1'b0;
          end else if (rc_q == RC_LAST) begin
            state_q  <= ST_RUN;
            resetn_q <= 1'b1;
          end else begin
            rc_q <= rc_q + RW'(1);
          end
        end
        ST_RUN: begin
          if (rst_btn) begin
            state_q  <= ST_HOLD;
            rc_q     <= '0;
            resetn_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_HOLD;
          rc_q     <= '0;
          resetn_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_if.btn_level   = level_w;
  assign bus_if.btn_press   = press_w;
  assign bus_if.btn_release = release_w;
  assign bus_if.cpu_resetn  = resetn_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=8, RST_HOLD=4.
module tb_button_conditioner;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  button_conditioner_if #(.NUM_BTN(4)) bus ();

  button_conditioner #(
    .NUM_BTN         (4),
    .ACTIVE_LOW_MASK (4'b0001),
    .DEBOUNCE_CYCLES (8),
    .RST_BTN         (0),
    .RST_HOLD        (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.btn_raw = 4'b0001;
    repeat (3) tick();
    chk("rst_level",   32'(bus.btn_level),   32'h0);
    chk("rst_press",   32'(bus.btn_press),   32'h0);
    chk("rst_release", 32'(bus.btn_release), 32'h0);
    chk("rst_resetn",  32'(bus.cpu_resetn),  32'h0);

    // Reset exit: HOLD one cycle, COUNT rc=0..3, RUN on the fifth edge.
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("stretch_low_%0d", i), 32'(bus.cpu_resetn), 32'h0);
    end
    tick();
    chk("stretch_high", 32'(bus.cpu_resetn), 32'h1);
    chk("actlow_idle",  32'(bus.btn_level),  32'h0);
    chk("no_exit_pulse", 32'(bus.btn_press | bus.btn_release), 32'h0);

    // Clean press on channel 1: 2 sync + 8 stable cycles.
    bus.btn_raw[1] = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk($sformatf("press1_wait_%0d", i), 32'({bus.btn_level[1], bus.btn_press[1]}), 32'h0);
    end
    tick();
    chk("press1_level", 32'(bus.btn_level), 32'h2);
    chk("press1_pulse", 32'(bus.btn_press), 32'h2);
    tick();
    chk("press1_pulse_end", 32'(bus.btn_press), 32'h0);
    chk("press1_hold",      32'(bus.btn_level), 32'h2);
    repeat (9) tick();

    bus.btn_raw[1] = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk($sformatf("rel1_wait_%0d", i), 32'({bus.btn_level[1], bus.btn_release[1]}), 32'h2);
    end
    tick();
    chk("rel1_level", 32'(bus.btn_level),   32'h0);
    chk("rel1_pulse", 32'(bus.btn_release), 32'h2);
    chk("rel1_nopress", 32'(bus.btn_press), 32'h0);
    tick();
    chk("rel1_pulse_end", 32'(bus.btn_release), 32'h0);

    // Bounce on channel 2: never stable long enough.
    for (int t = 0; t < 10; t++) begin
      bus.btn_raw[2] = ~bus.btn_raw[2];
      for (int k = 0; k < 3; k++) begin
        tick();
        chk($sformatf("bounce_%0d_%0d", t, k),
            32'({bus.btn_level[2], bus.btn_press[2], bus.btn_release[2]}), 32'h0);
      end
    end
    bus.btn_raw[2] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("bounce_tail_%0d", i),
          32'({bus.btn_level[2], bus.btn_press[2], bus.btn_release[2]}), 32'h0);
    end

    // Simultaneous press on channels 3..1.
    bus.btn_raw[3:1] = 3'b111;
    repeat (9) tick();
    chk("simul_wait", 32'(bus.btn_press), 32'h0);
    tick();
    chk("simul_pulse", 32'(bus.btn_press), 32'he);
    tick();
    chk("simul_pulse_end", 32'(bus.btn_press), 32'h0);
    chk("simul_level",     32'(bus.btn_level), 32'he);

    // Reset button (active-low channel 0) pressed while running.
    bus.btn_raw[0] = 1'b0;
    repeat (10) tick();
    chk("rb_level",      32'(bus.btn_level[0]),  32'h1);
    chk("rb_press",      32'(bus.btn_press[0]),  32'h1);
    chk("rb_resetn_lag", 32'(bus.cpu_resetn),    32'h1);
    tick();
    chk("rb_resetn_low", 32'(bus.cpu_resetn),    32'h0);
    repeat (5) tick();
    chk("rb_resetn_held", 32'(bus.cpu_resetn),   32'h0);

    bus.btn_raw[0] = 1'b1;
    repeat (10) tick();
    chk("rb_rel_level",  32'(bus.btn_level[0]),   32'h0);
    chk("rb_rel_pulse",  32'(bus.btn_release[0]), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("rb_rel_low_%0d", i), 32'(bus.cpu_resetn), 32'h0);
    end
    tick();
    chk("rb_rel_high", 32'(bus.cpu_resetn), 32'h1);

    // Mid-debounce reset on channel 1.
    bus.btn_raw[1] = 1'b0;
    repeat (10) tick();
    chk("mid_prep_level", 32'(bus.btn_level), 32'hc);
    bus.btn_raw[1] = 1'b1;
    repeat (7) tick();
    chk("mid_cnt5_level", 32'(bus.btn_level), 32'hc);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_level",   32'(bus.btn_level),   32'h0);
    chk("mid_rst_press",   32'(bus.btn_press),   32'h0);
    chk("mid_rst_release", 32'(bus.btn_release), 32'h0);
    chk("mid_rst_resetn",  32'(bus.cpu_resetn),  32'h0);
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk($sformatf("mid_relat_%0d", i), 32'(bus.btn_level), 32'h0);
    end
    tick();
    chk("mid_relat_level", 32'(bus.btn_level), 32'he);
    chk("mid_relat_press", 32'(bus.btn_press), 32'he);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
